// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 UART receiver that assembles two bytes (high first)
// into a 16-bit command word with sticky ready/overrun flags, a one-cycle
// framing-error pulse and an inter-byte timeout.
module uart_cmd_rcv #(
  parameter int unsigned BAUD_DIV     = 2604,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned BW       = $clog2(BAUD_DIV + 1);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TW       = $clog2(TO_LIMIT + 1);
  localparam logic [BW-1:0] HALF_BIT = BW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] FULL_BIT = BW'(BAUD_DIV);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hi_q, hi_d;
  logic          ptr_q, ptr_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          overrun_q, overrun_d;
  logic          frm_err_q, frm_err_d;
  logic          busy_q, busy_d;
  logic          start_edge;
  logic          baud_tick;
  logic          byte_ok;

  // State register; synchronizer flops preset to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      baud_q    <= '0;
      bitn_q    <= '0;
      shift_q   <= '0;
      hi_q      <= '0;
      ptr_q     <= 1'b0;
      to_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      baud_q    <= baud_d;
      bitn_q    <= bitn_d;
      shift_q   <= shift_d;
      hi_q      <= hi_d;
      ptr_q     <= ptr_d;
      to_q      <= to_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      overrun_q <= overrun_d;
      frm_err_q <= frm_err_d;
      busy_q    <= busy_d;
    end
  end

  // Bit FSM, byte assembly, timeout and flag next-state logic.
  always_comb begin
    state_d   = state_q;
    rx_meta_d = RX;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    baud_d    = baud_q;
    bitn_d    = bitn_q;
    shift_d   = shift_q;
    hi_d      = hi_q;
    ptr_d     = ptr_q;
    to_d      = to_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
    overrun_d = overrun_q & ~clr_cmd_rdy;
    frm_err_d = 1'b0;
    busy_d    = busy_q;
    byte_ok   = 1'b0;

    start_edge = (state_q == IDLE) && rx_prev_q && !rx_sync_q;
    baud_tick  = (baud_q == BW'(1));

    if (state_q != IDLE && !baud_tick) begin
      baud_d = baud_q - BW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          baud_d  = HALF_BIT;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          if (!rx_sync_q) begin
            state_d = DATA;
            baud_d  = FULL_BIT;
            bitn_d  = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          baud_d  = FULL_BIT;
          if (bitn_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (rx_sync_q) begin
            byte_ok = 1'b1;
          end else begin
            frm_err_d = 1'b1;
            ptr_d     = 1'b0;
          end
        end
      end
    endcase

    // Timeout only advances while a high byte waits in IDLE; any start edge restarts it.
    if (start_edge) begin
      to_d = '0;
    end else if (ptr_q && state_q == IDLE) begin
      if (to_q == TO_LAST) begin
        ptr_d = 1'b0;
        to_d  = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end

    // Completion overrides a same-cycle clear: set wins for cmd_rdy.
    if (byte_ok) begin
      if (!ptr_q) begin
        hi_d  = shift_q;
        ptr_d = 1'b1;
        to_d  = '0;
      end else begin
        cmd_d     = {hi_q, shift_q};
        cmd_rdy_d = 1'b1;
        ptr_d     = 1'b0;
        if (cmd_rdy_q && !clr_cmd_rdy) begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;
  assign overrun = overrun_q;
  assign busy    = busy_q;

endmodule
